// File: rtl/hazard_ctrl_pipe.sv
// Purpose: carries decode control through D/E, E/M, M/W; resolves branch/jump in E; emits stall/flush/forward selects.
// Latency: D inputs reach E outputs after 1 edge, M after 2, W after 3; hazard outputs are combinational.
// Backpressure: a load-use hazard stalls F/D for one cycle and bubbles E; a taken control transfer flushes D and E and overrides the stall.
module hazard_ctrl_pipe #(
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   // decode-stage control bundle
   input  logic              RegWriteD,
   input  logic              MemWriteD,
   input  logic              ALUSrcD,
   input  logic              JalrD,
   input  logic              JumpD,
   input  logic              BranchD,
   input  logic [1:0]        ResultSrcD,
   input  logic [2:0]        ALUControlD,
   input  logic [2:0]        f3D,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] RdD,
   // E-stage ALU flags from the subtraction
   input  logic              ZeroE,
   input  logic              SignE,
   // control transfer and hazard outputs
   output logic [1:0]        PCSrcE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   // E stage
   output logic              RegWriteE,
   output logic              MemWriteE,
   output logic              ALUSrcE,
   output logic [1:0]        ResultSrcE,
   output logic [2:0]        ALUControlE,
   output logic [REG_AW-1:0] Rs1E,
   output logic [REG_AW-1:0] Rs2E,
   output logic [REG_AW-1:0] RdE,
   // M stage
   output logic              RegWriteM,
   output logic              MemWriteM,
   output logic [1:0]        ResultSrcM,
   output logic [REG_AW-1:0] RdM,
   // W stage
   output logic              RegWriteW,
   output logic [1:0]        ResultSrcW,
   output logic [REG_AW-1:0] RdW
);

   // result select encoding for loads (value comes from data memory)
   localparam logic [1:0] RES_MEM = 2'b01;

   // PCSrc encodings
   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_TARGET = 2'b01;
   localparam logic [1:0] PC_ALU    = 2'b10;

   // forwarding select encodings
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // E-stage fields that are consumed internally and not exported
   logic        jalr_e;
   logic        jump_e;
   logic        branch_e;
   logic [2:0]  f3_e;

   // hazard intermediates
   logic        branch_cond;
   logic        taken;
   logic        lw_stall;

   // D/E register: bubble on flush or reset, otherwise load every cycle (never stalled)
   always_ff @(posedge clk) begin
      if (rst || FlushE) begin
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         ALUSrcE     <= 1'b0;
         ResultSrcE  <= 2'b00;
         ALUControlE <= 3'b000;
         jalr_e      <= 1'b0;
         jump_e      <= 1'b0;
         branch_e    <= 1'b0;
         f3_e        <= 3'b000;
         Rs1E        <= '0;
         Rs2E        <= '0;
         RdE         <= '0;
      end else begin
         RegWriteE   <= RegWriteD;
         MemWriteE   <= MemWriteD;
         ALUSrcE     <= ALUSrcD;
         ResultSrcE  <= ResultSrcD;
         ALUControlE <= ALUControlD;
         jalr_e      <= JalrD;
         jump_e      <= JumpD;
         branch_e    <= BranchD;
         f3_e        <= f3D;
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
         RdE         <= RdD;
      end
   end

   // E/M register: unconditional load, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= 2'b00;
         RdM        <= '0;
      end else begin
         RegWriteM  <= RegWriteE;
         MemWriteM  <= MemWriteE;
         ResultSrcM <= ResultSrcE;
         RdM        <= RdE;
      end
   end

   // M/W register: unconditional load, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
         RdW        <= '0;
      end else begin
         RegWriteW  <= RegWriteM;
         ResultSrcW <= ResultSrcM;
         RdW        <= RdM;
      end
   end

   // branch condition from funct3 and the E-stage subtraction flags
   always_comb begin
      branch_cond = 1'b0;
      case (f3_e)
         3'b000:  branch_cond = ZeroE;   // beq
         3'b001:  branch_cond = ~ZeroE;  // bne
         3'b100:  branch_cond = SignE;   // blt
         3'b101:  branch_cond = ~SignE;  // bge
         default: branch_cond = 1'b0;    // unsupported compare never taken
      endcase
   end

   // next-PC select: jalr beats jal beats conditional branch
   always_comb begin
      PCSrcE = PC_PLUS4;
      if (jalr_e) begin
         PCSrcE = PC_ALU;
      end else if (jump_e) begin
         PCSrcE = PC_TARGET;
      end else if (branch_e && branch_cond) begin
         PCSrcE = PC_TARGET;
      end
   end

   // stall/flush: a taken transfer wins over load-use so the target gets fetched
   always_comb begin
      taken    = (PCSrcE != PC_PLUS4);
      lw_stall = (ResultSrcE == RES_MEM) && (RdE != '0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));
      FlushD   = taken;
      FlushE   = taken | lw_stall;
      StallF   = lw_stall & ~taken;
      StallD   = lw_stall & ~taken;
   end

   // operand forwarding: the younger M result beats W; x0 never forwards
   always_comb begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
         ForwardAE = FWD_M;
      end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
         ForwardAE = FWD_W;
      end
      if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
         ForwardBE = FWD_M;
      end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
         ForwardBE = FWD_W;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe: reset, latency, load-use, forwarding, branches, jumps, conflicts.
// Each scenario task drives the D bundle, steps the clock and compares against hand-derived values.
// Inputs change 1 time unit after the rising edge; outputs are sampled there as well.
module tb_hazard_ctrl_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       RegWriteD, MemWriteD, ALUSrcD, JalrD, JumpD, BranchD;
   logic [1:0] ResultSrcD;
   logic [2:0] ALUControlD, f3D;
   logic [4:0] Rs1D, Rs2D, RdD;
   logic       ZeroE, SignE;
   logic [1:0] PCSrcE;
   logic       StallF, StallD, FlushD, FlushE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       RegWriteE, MemWriteE, ALUSrcE;
   logic [1:0] ResultSrcE;
   logic [2:0] ALUControlE;
   logic [4:0] Rs1E, Rs2E, RdE;
   logic       RegWriteM, MemWriteM;
   logic [1:0] ResultSrcM;
   logic [4:0] RdM;
   logic       RegWriteW;
   logic [1:0] ResultSrcW;
   logic [4:0] RdW;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl_pipe #(.REG_AW(5)) dut (
      .clk(clk), .rst(rst),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
      .JalrD(JalrD), .JumpD(JumpD), .BranchD(BranchD),
      .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .f3D(f3D),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .ZeroE(ZeroE), .SignE(SignE),
      .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD),
      .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
      .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .ResultSrcM(ResultSrcM), .RdM(RdM),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_d(input logic rw, input logic mw, input logic as,
                          input logic jr, input logic jp, input logic br,
                          input logic [1:0] rs, input logic [2:0] alu,
                          input logic [2:0] f3, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd);
      RegWriteD = rw; MemWriteD = mw; ALUSrcD = as;
      JalrD = jr; JumpD = jp; BranchD = br;
      ResultSrcD = rs; ALUControlD = alu; f3D = f3;
      Rs1D = r1; Rs2D = r2; RdD = rd;
   endtask

   task automatic clear_d();
      drive_d(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic do_reset();
      clear_d();
      ZeroE = 1'b0; SignE = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ZeroE = 1'b1; SignE = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive_d(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
                 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
         step();
      end
      checks++; if ({RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE, Rs1E, Rs2E, RdE} !== '0) begin
         errors++; $display("FAIL reset_E_regs got %0h exp 0", {RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE, Rs1E, Rs2E, RdE}); end
      checks++; if ({RegWriteM, MemWriteM, ResultSrcM, RdM, RegWriteW, ResultSrcW, RdW} !== '0) begin
         errors++; $display("FAIL reset_MW_regs got %0h exp 0", {RegWriteM, MemWriteM, ResultSrcM, RdM, RegWriteW, ResultSrcW, RdW}); end
      checks++; if (PCSrcE !== 2'b00) begin errors++; $display("FAIL reset_PCSrcE got %0h exp 0", PCSrcE); end
      checks++; if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
         errors++; $display("FAIL reset_stall_flush got %0b exp 0000", {StallF, StallD, FlushD, FlushE}); end
      checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin
         errors++; $display("FAIL reset_forward got %0b exp 0000", {ForwardAE, ForwardBE}); end
      // release: first bundle on E after one edge, M after two, W after three
      rst = 1'b0;
      ZeroE = 1'b0; SignE = 1'b0;
      drive_d(1, 0, 1, 0, 0, 0, 2'b01, 3'b010, 3'b000, 5'd7, 5'd8, 5'd9);
      step();
      clear_d();
      checks++; if ({RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE} !== 8'b1_0_1_01_010) begin
         errors++; $display("FAIL release_E_ctrl got %0b exp 10101010", {RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE}); end
      checks++; if ({Rs1E, Rs2E, RdE} !== {5'd7, 5'd8, 5'd9}) begin
         errors++; $display("FAIL release_E_regs got %0h exp %0h", {Rs1E, Rs2E, RdE}, {5'd7, 5'd8, 5'd9}); end
      checks++; if (RdM !== 5'd0) begin errors++; $display("FAIL release_RdM_early got %0d exp 0", RdM); end
      step();
      checks++; if ({RegWriteM, ResultSrcM, RdM} !== {1'b1, 2'b01, 5'd9}) begin
         errors++; $display("FAIL latency_M got %0h exp %0h", {RegWriteM, ResultSrcM, RdM}, {1'b1, 2'b01, 5'd9}); end
      step();
      checks++; if ({RegWriteW, ResultSrcW, RdW} !== {1'b1, 2'b01, 5'd9}) begin
         errors++; $display("FAIL latency_W got %0h exp %0h", {RegWriteW, ResultSrcW, RdW}, {1'b1, 2'b01, 5'd9}); end
   endtask

   task automatic test_load_use();
      do_reset();
      drive_d(1, 0, 1, 0, 0, 0, 2'b01, 3'b000, 3'b000, 5'd2, 5'd0, 5'd5);  // lw x5
      step();
      drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd5, 5'd6, 5'd7);  // add x7,x5,x6
      #1;
      checks++; if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
         errors++; $display("FAIL lu_stall got %0b exp 1110", {StallF, StallD, FlushE, FlushD}); end
      step();
      checks++; if ({RegWriteE, RdE} !== {1'b0, 5'd0}) begin
         errors++; $display("FAIL lu_bubble got %0h exp 0", {RegWriteE, RdE}); end
      checks++; if ({StallF, StallD, FlushE} !== 3'b000) begin
         errors++; $display("FAIL lu_one_cycle got %0b exp 000", {StallF, StallD, FlushE}); end
      step();
      clear_d();
      checks++; if (RdE !== 5'd7) begin errors++; $display("FAIL lu_add_in_E got %0d exp 7", RdE); end
      checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL lu_ForwardAE got %0b exp 01", ForwardAE); end
      checks++; if (ForwardBE !== 2'b00) begin errors++; $display("FAIL lu_ForwardBE got %0b exp 00", ForwardBE); end
   endtask

   task automatic test_forwarding();
      logic [4:0] rd_old [3];
      logic [4:0] rd_new [3];
      logic [1:0] exp_fwd [3];
      rd_old = '{5'd3, 5'd3, 5'd0};
      rd_new = '{5'd3, 5'd0, 5'd0};
      exp_fwd = '{2'b10, 2'b01, 2'b00};
      for (int i = 0; i < 3; i++) begin
         do_reset();
         drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd1, 5'd2, rd_old[i]);
         step();
         drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd1, 5'd2, rd_new[i]);
         step();
         drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd3, 5'd3, 5'd9);
         step();
         clear_d();
         checks++; if (ForwardAE !== exp_fwd[i]) begin
            errors++; $display("FAIL fwd_A_case%0d got %0b exp %0b", i, ForwardAE, exp_fwd[i]); end
         checks++; if (ForwardBE !== exp_fwd[i]) begin
            errors++; $display("FAIL fwd_B_case%0d got %0b exp %0b", i, ForwardBE, exp_fwd[i]); end
      end
   endtask

   task automatic test_branches();
      logic [2:0] f3s  [6];
      logic       zs   [6];
      logic       ss   [6];
      logic [1:0] exps [6];
      f3s  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b101, 3'b010};
      zs   = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b0,   1'b1};
      ss   = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1};
      exps = '{2'b01,  2'b00,  2'b01,  2'b00,  2'b01,  2'b00};
      do_reset();
      // beq taken: both D and E get flushed, successor becomes a bubble
      ZeroE = 1'b1;
      drive_d(0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 3'b000, 5'd1, 5'd2, 5'd0);
      step();
      drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd1, 5'd1, 5'd4);
      #1;
      checks++; if ({PCSrcE, FlushD, FlushE, StallF} !== 5'b01_1_1_0) begin
         errors++; $display("FAIL beq_taken got %0b exp 01110", {PCSrcE, FlushD, FlushE, StallF}); end
      step();
      clear_d();
      checks++; if ({RegWriteE, RdE, PCSrcE} !== {1'b0, 5'd0, 2'b00}) begin
         errors++; $display("FAIL beq_bubble got %0h exp 0", {RegWriteE, RdE, PCSrcE}); end
      for (int i = 0; i < 6; i++) begin
         ZeroE = zs[i]; SignE = ss[i];
         drive_d(0, 0, 0, 0, 0, 1, 2'b00, 3'b001, f3s[i], 5'd1, 5'd2, 5'd0);
         step();
         clear_d();
         checks++; if (PCSrcE !== exps[i]) begin
            errors++; $display("FAIL branch_f3_%0b_z%0b_s%0b got %0b exp %0b", f3s[i], zs[i], ss[i], PCSrcE, exps[i]); end
         step();
      end
      ZeroE = 1'b0; SignE = 1'b0;
   endtask

   task automatic test_jumps();
      do_reset();
      drive_d(1, 0, 0, 0, 1, 0, 2'b10, 3'b000, 3'b000, 5'd0, 5'd0, 5'd1);  // jal x1
      step();
      drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd2, 5'd3, 5'd7);  // successor
      #1;
      checks++; if ({PCSrcE, FlushD, FlushE} !== 4'b01_1_1) begin
         errors++; $display("FAIL jal_pcsrc got %0b exp 0111", {PCSrcE, FlushD, FlushE}); end
      step();
      clear_d();
      checks++; if (RegWriteE !== 1'b0) begin errors++; $display("FAIL jal_succ_bubble got %0b exp 0", RegWriteE); end
      step();
      checks++; if ({RegWriteW, ResultSrcW, RdW} !== {1'b1, 2'b10, 5'd1}) begin
         errors++; $display("FAIL jal_reaches_W got %0h exp %0h", {RegWriteW, ResultSrcW, RdW}, {1'b1, 2'b10, 5'd1}); end
      step();
      checks++; if ({RegWriteW, RdW} !== {1'b0, 5'd0}) begin
         errors++; $display("FAIL jal_succ_not_W got %0h exp 0", {RegWriteW, RdW}); end
      drive_d(1, 0, 1, 1, 0, 0, 2'b10, 3'b000, 3'b000, 5'd4, 5'd0, 5'd1);  // jalr x1
      step();
      clear_d();
      checks++; if (PCSrcE !== 2'b10) begin errors++; $display("FAIL jalr_pcsrc got %0b exp 10", PCSrcE); end
      step();
   endtask

   task automatic test_simultaneous();
      do_reset();
      // load-flagged beq in E with matching Rs1D
      drive_d(1, 0, 0, 0, 0, 1, 2'b01, 3'b001, 3'b000, 5'd1, 5'd2, 5'd5);
      step();
      drive_d(1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd5, 5'd0, 5'd6);
      ZeroE = 1'b1;
      #1;
      checks++; if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
         errors++; $display("FAIL simul_taken got %0b exp 0011", {StallF, StallD, FlushD, FlushE}); end
      ZeroE = 1'b0;
      #1;
      checks++; if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
         errors++; $display("FAIL simul_not_taken got %0b exp 1101", {StallF, StallD, FlushD, FlushE}); end
      // Rs2D match and x0 suppression
      Rs1D = 5'd0; Rs2D = 5'd5;
      #1;
      checks++; if (StallF !== 1'b1) begin errors++; $display("FAIL lu_rs2_match got %0b exp 1", StallF); end
      Rs2D = 5'd6;
      #1;
      checks++; if ({StallF, FlushE} !== 2'b00) begin errors++; $display("FAIL lu_no_match got %0b exp 00", {StallF, FlushE}); end
      step();
   endtask

   task automatic test_midop_reset();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         drive_d(1, 1, 0, 0, 0, 0, 2'b01, 3'b000, 3'b000, 5'd0, 5'd0, 5'(i + 10));
         step();
      end
      checks++; if ({RdE, RdM, RdW} !== {5'd13, 5'd12, 5'd11}) begin
         errors++; $display("FAIL midop_fill got %0h exp %0h", {RdE, RdM, RdW}, {5'd13, 5'd12, 5'd11}); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_d();
      checks++; if ({RegWriteE, RegWriteM, RegWriteW, MemWriteE, MemWriteM, RdE, RdM, RdW} !== '0) begin
         errors++; $display("FAIL midop_reset got %0h exp 0", {RegWriteE, RegWriteM, RegWriteW, MemWriteE, MemWriteM, RdE, RdM, RdW}); end
   endtask

   initial begin
      rst = 1'b1;
      clear_d();
      ZeroE = 1'b0; SignE = 1'b0;
      #1;
      test_reset();
      test_load_use();
      test_forwarding();
      test_branches();
      test_jumps();
      test_simultaneous();
      test_midop_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
